// File: rtl/data_types_pkg.sv
// Shared types for the serial blocks: control register layout and receiver state encoding.
// Pure type definitions; no latency or flow-control behaviour of its own.
package data_types_pkg;

  localparam int BR_DIV_W = 10;

  typedef struct packed {
    logic [BR_DIV_W-1:0] br_div;  // bit period in clk cycles
    logic                word;    // 1 = 9 data bits, 0 = 8
    logic                stop;    // 1 = two stop bits, 0 = one
  } ctrl_reg_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset loads RST_VAL into both stages.
// Latency two clk cycles; no backpressure.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8/9 data bits MSB first, 1/2 stop bits, per-frame latched bit period.
// Word appears one cycle after the final stop sample; single-entry holding register, overrun drops the new word.
module uart_rx
  import data_types_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  ctrl_reg_t  control,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err
);

  state_t              state, state_n;
  logic                rx_s, rx_prev;
  logic [BR_DIV_W-1:0] cnt, br_l, half_m1, full_m1;
  logic                word_l, stop_l, stop_cnt;
  logic [3:0]          bit_cnt, last_bit;
  logic [8:0]          shreg;
  logic                sample, good, bad;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign half_m1  = (br_l >> 1) - 10'd1;
  assign full_m1  = br_l - 10'd1;
  assign last_bit = word_l ? 4'd8 : 4'd7;
  assign rx_busy  = (state != IDLE);

  always_comb begin
    state_n = state;
    sample  = 1'b0;
    good    = 1'b0;
    bad     = 1'b0;
    case (state)
      IDLE: if (rx_prev && !rx_s) state_n = START;
      START: begin
        if (cnt == half_m1) begin
          sample  = 1'b1;
          state_n = rx_s ? IDLE : DATA;  // line back high: false start
        end
      end
      DATA: begin
        if (cnt == full_m1) begin
          sample = 1'b1;
          if (bit_cnt == last_bit) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == full_m1) begin
          sample = 1'b1;
          if (!rx_s) begin
            bad     = 1'b1;
            state_n = IDLE;
          end else if (!(stop_l && !stop_cnt)) begin
            // leave mid-stop-bit so an immediately following start edge is seen
            good    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_prev     <= 1'b1;
      br_l        <= '0;
      word_l      <= 1'b0;
      stop_l      <= 1'b0;
      stop_cnt    <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state   <= state_n;
      rx_prev <= rx_s;
      cnt     <= (state == IDLE || state_n != state || sample) ? '0 : cnt + 10'd1;

      if (state == IDLE && state_n == START) begin
        br_l     <= control.br_div;
        word_l   <= control.word;
        stop_l   <= control.stop;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        shreg    <= '0;
      end
      if (state == DATA && sample) begin
        shreg   <= {shreg[7:0], rx_s};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == STOP && sample) stop_cnt <= 1'b1;

      frame_err   <= bad;
      overrun_err <= good && rx_valid && !rx_ack;
      if (good && (!rx_valid || rx_ack)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven from a behavioural transmitter, results checked against a frame-level model.
module tb_uart_rx;
  import data_types_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rx_in, rx_ack;
  ctrl_reg_t  control;
  logic [8:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun_err;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .control     (control),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  int n_assert = 0, n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
  logic       m_valid = 1'b0;
  logic [8:0] m_data  = '0;

  // every high cycle of an error flag counts, so a stretched pulse shows up as an extra event
  always @(negedge clk) begin
    if (frame_err)   fe_cnt++;
    if (overrun_err) ov_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk($sformatf("%s.rx_valid", tag), 16'(rx_valid), 16'(m_valid));
    chk($sformatf("%s.rx_data", tag), 16'(rx_data), 16'(m_data));
    chk($sformatf("%s.rx_busy", tag), 16'(rx_busy), 16'h0);
    chk($sformatf("%s.frame_err", tag), 16'(frame_err), 16'h0);
    chk($sformatf("%s.overrun_err", tag), 16'(overrun_err), 16'h0);
    chk($sformatf("%s.frame_err_events", tag), 16'(fe_cnt), 16'(exp_fe));
    chk($sformatf("%s.overrun_events", tag), 16'(ov_cnt), 16'(exp_ov));
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  // ackmode: 0 none, 1 ack in the final-stop-sample cycle, 2 ack pulse after the frame.
  // rst_at >= 0 asserts reset at that cycle of the frame and abandons it.
  task automatic frame(input string tag, input logic [8:0] d, input bit wd, input bit ts,
                       input bit bad, input int ackmode, input int gap, input int rst_at);
    int   B, h, n, ns, s_fin, s_first, total;
    bit   b_first, b_pre, b_post, aborted;
    logic bits[$];
    logic [8:0] word_v;
    B  = int'(control.br_div);
    h  = B / 2;
    n  = wd ? 9 : 8;
    ns = ts ? 2 : 1;
    control.word = wd;
    control.stop = ts;
    // line low after cycle 0 reaches rx_s two edges later, the edge is acted on one edge after that;
    // start sampled half a bit in, every later sample one full bit after the previous
    s_first = 3 + h + (n + 1) * B;
    s_fin   = 3 + h + (n + ns) * B;
    total   = (n + ns + 1) * B + gap;
    bits.push_back(1'b0);
    for (int i = n - 1; i >= 0; i--) bits.push_back(d[i]);
    for (int i = 0; i < ns; i++) bits.push_back(!bad);
    aborted = 1'b0;
    b_first = 1'b0;
    b_pre   = 1'b0;
    b_post  = 1'b1;
    for (int c = 0; c < total; c++) begin
      if (c == rst_at) begin
        aborted = 1'b1;
        break;
      end
      rx_in  = (c < (n + ns + 1) * B) ? bits[c / B] : 1'b1;
      rx_ack = (ackmode == 1 && c == s_fin - 1);
      if (c == s_first)   b_first = rx_busy;
      if (c == s_fin - 1) b_pre   = rx_busy;
      if (c == s_fin)     b_post  = rx_busy;
      tick();
    end
    rx_ack = 1'b0;
    if (aborted) begin
      rst   = 1'b1;
      rx_in = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      m_valid = 1'b0;
      m_data  = '0;
      chk_state(tag);
      return;
    end
    chk($sformatf("%s.busy_after_first_stop", tag), 16'(b_first), 16'(ts && !bad));
    chk($sformatf("%s.busy_before_last_stop", tag), 16'(b_pre), 16'(!(bad && ts)));
    chk($sformatf("%s.busy_after_last_stop", tag), 16'(b_post), 16'h0);
    if (!bad) begin
      word_v = wd ? d : {1'b0, d[7:0]};
      if (!m_valid || ackmode == 1) begin
        m_data  = word_v;
        m_valid = 1'b1;
      end else begin
        exp_ov++;
      end
    end else begin
      exp_fe++;
      if (ackmode == 1) m_valid = 1'b0;
    end
    if (ackmode == 2) ack_pulse();
    chk_state(tag);
  endtask

  initial begin
    rst     = 1'b1;
    rx_in   = 1'b1;
    rx_ack  = 1'b0;
    control = '{br_div: 10'd16, word: 1'b0, stop: 1'b0};
    repeat (4) tick();
    chk_state("reset_held");
    rst = 1'b0;
    tick();
    chk_state("reset_released");

    control.br_div = 10'd16;
    frame("8n1_a5", 9'h0A5, 1'b0, 1'b0, 1'b0, 2, 16, -1);
    control.br_div = 10'd10;
    frame("9n2_1c3", 9'h1C3, 1'b1, 1'b1, 1'b0, 0, 10, -1);
    chk("9n2_1c3.data_direct", 16'(rx_data), 16'h01C3);
    ack_pulse();

    // 5-cycle low glitch, shorter than half a bit
    control.br_div = 10'd16;
    rx_in = 1'b0;
    repeat (4) tick();
    chk("glitch.busy_in_start", 16'(rx_busy), 16'h1);
    tick();
    rx_in = 1'b1;
    repeat (30) tick();
    chk_state("glitch");

    frame("bad_stop_3c", 9'h03C, 1'b0, 1'b0, 1'b1, 0, 16, -1);
    frame("after_bad_55", 9'h055, 1'b0, 1'b0, 1'b0, 2, 16, -1);

    frame("b2b_11", 9'h011, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    frame("b2b_22_noack", 9'h022, 1'b0, 1'b0, 1'b0, 0, 16, -1);
    chk("b2b_22_noack.data_direct", 16'(rx_data), 16'h0011);
    ack_pulse();
    frame("b2b_11_again", 9'h011, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    frame("b2b_22_ack", 9'h022, 1'b0, 1'b0, 1'b0, 1, 16, -1);
    chk("b2b_22_ack.data_direct", 16'(rx_data), 16'h0022);
    ack_pulse();

    frame("loop_5a", 9'h05A, 1'b0, 1'b0, 1'b0, 0, 16, -1);
    chk("loop_5a.data_direct", 16'(rx_data), 16'h005A);
    frame("loop_rst_mid", 9'h0C3, 1'b0, 1'b0, 1'b0, 0, 16, 5 * 16);
    frame("loop_after_rst", 9'h096, 1'b0, 1'b0, 1'b0, 2, 16, -1);

    for (int k = 0; k < 24; k++) begin
      logic [8:0] d;
      bit wd, ts, bad;
      int am;
      control.br_div = 10'($urandom_range(4, 20));
      d   = 9'($urandom);
      wd  = 1'($urandom);
      ts  = 1'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      am  = int'($urandom_range(0, 2));
      frame($sformatf("rand%0d", k), d, wd, ts, bad, am, int'(control.br_div) + 4, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
